// File: rtl/ndn_pkg.sv
// rtl/ndn_pkg.sv - shared constants and state encoding for the NDN-to-MCU transmit path
// Purpose: packet geometry, source index width and scheduler state encoding.
// Ports: none (package).
package ndn_pkg;

  localparam int PREFIX_W   = 64;
  localparam int DATA_BYTES = 32;
  // Width of a source index; covers the maximum of 8 sources.
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    WAIT_TX = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mcu_tx_scheduler_if.sv
// rtl/mcu_tx_scheduler_if.sv - source/transmitter bus bundle of the MCU transmit scheduler
// Purpose: groups the request-side and SPI-side signals of mcu_tx_scheduler.
// Ports (members):
//   req_valid, req_prefix, req_byte, req_byte_valid : per-source request and payload
//   gnt, req_done                                   : per-source grant and completion
//   spi_start, spi_prefix, spi_byte, spi_byte_valid,
//   spi_abort, spi_done                             : SPI transmitter link
//   busy, err_timeout, err_src                      : status
// Modports: master = scheduler side, slave = sources/transmitter side.
interface mcu_tx_scheduler_if
  import ndn_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*PREFIX_W-1:0] req_prefix;
  logic [NUM_REQ*8-1:0]        req_byte;
  logic [NUM_REQ-1:0]          req_byte_valid;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          req_done;
  logic                        spi_start;
  logic [PREFIX_W-1:0]         spi_prefix;
  logic [7:0]                  spi_byte;
  logic                        spi_byte_valid;
  logic                        spi_abort;
  logic                        spi_done;
  logic                        busy;
  logic                        err_timeout;
  logic [IDX_W-1:0]            err_src;

  modport master (
    input  req_valid, req_prefix, req_byte, req_byte_valid, spi_done,
    output gnt, req_done, spi_start, spi_prefix, spi_byte, spi_byte_valid,
           spi_abort, busy, err_timeout, err_src
  );

  modport slave (
    output req_valid, req_prefix, req_byte, req_byte_valid, spi_done,
    input  gnt, req_done, spi_start, spi_prefix, spi_byte, spi_byte_valid,
           spi_abort, busy, err_timeout, err_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner selection
// Purpose: picks the first requesting source after the pointer, wrapping.
// Ports:
//   req_i      in  NUM_REQ  request vector
//   ptr_i      in  IDX_W    last-served source; search starts at ptr_i+1
//   gnt_next_o out NUM_REQ  one-hot winner (all zero when no request)
//   idx_o      out IDX_W    index of the winner
module rr_arbiter
  import ndn_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_next_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_next_o = '0;
    idx_o      = '0;
    found      = 1'b0;
    cand       = 0;
    // k runs 1..NUM_REQ so the last-served source is examined last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found            = 1'b1;
        gnt_next_o[cand] = 1'b1;
        idx_o            = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mcu_tx_scheduler.sv
// rtl/mcu_tx_scheduler.sv - round-robin scheduler sharing the SPI transmit path among sources
// Purpose: grants one source at a time, forwards its prefix and payload bytes to
//          the SPI transmitter, waits for spi_done, and aborts sources that stall.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  mcu_tx_scheduler_if.master  request, SPI and status signals
module mcu_tx_scheduler
  import ndn_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mcu_tx_scheduler_if.master  bus
);

  localparam int BC_W = $clog2(DATA_BYTES + 1);
  localparam int SC_W = $clog2(TIMEOUT + 1);

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                spi_start_q, spi_start_d;
  logic [PREFIX_W-1:0] spi_prefix_q, spi_prefix_d;
  logic [7:0]          spi_byte_q, spi_byte_d;
  logic                spi_byte_valid_q, spi_byte_valid_d;
  logic                spi_abort_q, spi_abort_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                err_timeout_q, err_timeout_d;
  logic [IDX_W-1:0]    err_src_q, err_src_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                byte_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .gnt_next_o (arb_gnt),
    .idx_o      (arb_idx)
  );

  // gnt_q is one-hot while streaming, so masking picks the granted source's strobe
  // and bytes from every other source fall away.
  assign byte_in = |(bus.req_byte_valid & gnt_q);

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    gidx_d           = gidx_q;
    gnt_d            = gnt_q;
    byte_cnt_d       = byte_cnt_q;
    stall_cnt_d      = stall_cnt_q;
    spi_start_d      = 1'b0;
    spi_prefix_d     = spi_prefix_q;
    spi_byte_d       = spi_byte_q;
    spi_byte_valid_d = 1'b0;
    spi_abort_d      = 1'b0;
    req_done_d       = '0;
    err_timeout_d    = 1'b0;
    err_src_d        = err_src_q;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          gnt_d        = arb_gnt;
          gidx_d       = arb_idx;
          spi_prefix_d = bus.req_prefix[arb_idx*PREFIX_W +: PREFIX_W];
          spi_start_d  = 1'b1;
          byte_cnt_d   = '0;
          stall_cnt_d  = '0;
          state_d      = STREAM;
        end
      end

      STREAM: begin
        if (byte_in) begin
          // A byte always wins over a pending timeout on the same cycle.
          spi_byte_d       = bus.req_byte[gidx_q*8 +: 8];
          spi_byte_valid_d = 1'b1;
          stall_cnt_d      = '0;
          byte_cnt_d       = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BC_W'(DATA_BYTES - 1)) begin
            gnt_d   = '0;
            state_d = WAIT_TX;
          end
        end else begin
          if (stall_cnt_q != SC_W'(TIMEOUT)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          if (stall_cnt_q == SC_W'(TIMEOUT - 1)) begin
            gnt_d         = '0;
            spi_abort_d   = 1'b1;
            err_timeout_d = 1'b1;
            err_src_d     = gidx_q;
            ptr_d         = gidx_q;
            state_d       = IDLE;
          end
        end
      end

      WAIT_TX: begin
        if (bus.spi_done) begin
          req_done_d = NUM_REQ'(1) << gidx_q;
          ptr_d      = gidx_q;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= IDX_W'(NUM_REQ - 1);
      gidx_q           <= '0;
      gnt_q            <= '0;
      byte_cnt_q       <= '0;
      stall_cnt_q      <= '0;
      spi_start_q      <= 1'b0;
      spi_prefix_q     <= '0;
      spi_byte_q       <= '0;
      spi_byte_valid_q <= 1'b0;
      spi_abort_q      <= 1'b0;
      req_done_q       <= '0;
      err_timeout_q    <= 1'b0;
      err_src_q        <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      gidx_q           <= gidx_d;
      gnt_q            <= gnt_d;
      byte_cnt_q       <= byte_cnt_d;
      stall_cnt_q      <= stall_cnt_d;
      spi_start_q      <= spi_start_d;
      spi_prefix_q     <= spi_prefix_d;
      spi_byte_q       <= spi_byte_d;
      spi_byte_valid_q <= spi_byte_valid_d;
      spi_abort_q      <= spi_abort_d;
      req_done_q       <= req_done_d;
      err_timeout_q    <= err_timeout_d;
      err_src_q        <= err_src_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.req_done       = req_done_q;
  assign bus.spi_start      = spi_start_q;
  assign bus.spi_prefix     = spi_prefix_q;
  assign bus.spi_byte       = spi_byte_q;
  assign bus.spi_byte_valid = spi_byte_valid_q;
  assign bus.spi_abort      = spi_abort_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.err_timeout    = err_timeout_q;
  assign bus.err_src        = err_src_q;

endmodule

// File: tb/tb_mcu_tx_scheduler.sv
// tb/tb_mcu_tx_scheduler.sv - scoreboard bench for mcu_tx_scheduler
module tb_mcu_tx_scheduler;
  import ndn_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcu_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

  mcu_tx_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  // source configuration
  int          stall_after [NR];
  int          gap         [NR];
  int          pkt_left    [NR];
  logic [63:0] pfx         [NR];

  // scoreboard
  int          exp_src[$];
  logic [63:0] exp_prefix[$];
  int          exp_byte[$];
  int          exp_end[$];   // src for req_done, 16+src for abort

  task automatic push_pkt(input int src, input int nbytes, input bit aborted);
    exp_src.push_back(src);
    exp_prefix.push_back(pfx[src]);
    for (int b = 0; b < nbytes; b++) exp_byte.push_back((src * 64 + b) & 255);
    exp_end.push_back(aborted ? 16 + src : src);
  endtask

  // sources + transmitter model
  int           resp_cnt, gap_ctr, tx_cnt, done_timer, g;
  logic [NR-1:0] gnt_prev;
  initial begin
    bus.req_valid = '0; bus.req_byte_valid = '0; bus.req_byte = '0;
    bus.req_prefix = '0; bus.spi_done = 1'b0;
    resp_cnt = 0; gap_ctr = 0; tx_cnt = 0; done_timer = 0; gnt_prev = '0; g = 0;
    forever begin
      @(posedge clk); #1;
      bus.spi_done = 1'b0;
      for (int i = 0; i < NR; i++) begin
        bus.req_byte_valid[i]   = 1'($urandom_range(0, 1));
        bus.req_byte[i*8 +: 8]  = 8'hEE;
      end
      if (rst) begin
        bus.req_byte_valid = '0;
        resp_cnt = 0; gap_ctr = 0; gnt_prev = '0; tx_cnt = 0; done_timer = 0;
      end else begin
        g = oh_idx(bus.gnt);
        if (bus.gnt != '0 && gnt_prev == '0) begin
          pkt_left[g]--; resp_cnt = 0; gap_ctr = 0;
        end
        if (bus.gnt != '0) begin
          bus.req_byte_valid[g] = 1'b0;
          if (gap_ctr > 0) gap_ctr--;
          else if (resp_cnt < stall_after[g]) begin
            bus.req_byte[g*8 +: 8] = 8'(g * 64 + resp_cnt);
            bus.req_byte_valid[g]  = 1'b1;
            resp_cnt++;
            gap_ctr = gap[g];
          end
        end
        gnt_prev = bus.gnt;
        if (bus.spi_start || bus.spi_abort) tx_cnt = 0;
        if (bus.spi_byte_valid) begin
          tx_cnt++;
          if (tx_cnt == 3) bus.spi_done = 1'b1;          // stray, must be ignored
          if (tx_cnt == DATA_BYTES) done_timer = 6;
        end
        if (done_timer > 0) begin
          done_timer--;
          if (done_timer == 0) bus.spi_done = 1'b1;
        end
      end
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i]          = (pkt_left[i] > 0);
        bus.req_prefix[i*64 +: 64] = pfx[i];
      end
    end
  end

  // output monitor
  int   since_byte = 0;
  logic prev_done  = 1'b0;
  int   s, ev;
  always @(negedge clk) begin
    if (!rst) begin
      since_byte = bus.spi_byte_valid ? 0 : since_byte + 1;
      if (bus.spi_start) begin
        if (exp_src.size() == 0) check_eq("start_extra", 1, 0);
        else begin
          s = exp_src.pop_front();
          check_eq("gnt_onehot", 64'(bus.gnt), 64'(1) << s);
          check_eq("prefix", bus.spi_prefix, exp_prefix.pop_front());
        end
      end
      if (bus.spi_byte_valid) begin
        if (exp_byte.size() == 0) check_eq("byte_extra", 1, 0);
        else check_eq("byte", 64'(bus.spi_byte), 64'(exp_byte.pop_front()));
      end
      if (bus.req_done != '0 || bus.spi_abort) begin
        ev = bus.spi_abort ? 16 + int'(bus.err_src) : oh_idx(bus.req_done);
        if (exp_end.size() == 0) check_eq("end_extra", 1, 0);
        else check_eq("end_evt", 64'(ev), 64'(exp_end.pop_front()));
        if (bus.spi_abort) begin
          check_eq("abort_err_pulse", 64'(bus.err_timeout), 1);
          check_eq("abort_stall_cycles", 64'(since_byte), TO);
          check_eq("abort_no_done", 64'(bus.req_done), 0);
        end else begin
          check_eq("done_latency", 64'(prev_done), 1);
        end
      end
      if (bus.err_timeout && !bus.spi_abort) check_eq("err_without_abort", 0, 1);
      prev_done = bus.spi_done;
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_end.size() != 0 || bus.busy) && n < 4000) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_drain"}, 64'(n < 4000), 1);
    check_eq({tag, "_idle"}, 64'(bus.busy), 0);
    check_eq({tag, "_bytes_left"}, 64'(exp_byte.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      stall_after[i] = DATA_BYTES; gap[i] = 0; pkt_left[i] = 0;
      pfx[i] = 64'h0C0C_0000_0000_0000 + 64'(i) * 64'h0001_1111_0000_1111;
    end
    pfx[0] = 64'hA5A5_0000_1234_5678;
    repeat (3) @(posedge clk); #2;
    check_eq("rst_gnt", 64'(bus.gnt), 0);
    check_eq("rst_busy", 64'(bus.busy), 0);
    check_eq("rst_start", 64'(bus.spi_start), 0);
    check_eq("rst_bv", 64'(bus.spi_byte_valid), 0);
    check_eq("rst_done", 64'(bus.req_done), 0);
    check_eq("rst_abort", 64'(bus.spi_abort), 0);
    check_eq("rst_err", 64'(bus.err_timeout), 0);
    check_eq("rst_err_src", 64'(bus.err_src), 0);
    check_eq("rst_prefix", bus.spi_prefix, 0);
    @(negedge clk); rst = 1'b0;

    // single source, grant latency
    push_pkt(0, DATA_BYTES, 1'b0);
    pkt_left[0] = 1;
    @(posedge clk); #2;
    @(negedge clk); check_eq("start_early", 64'(bus.spi_start), 0);
    @(negedge clk); check_eq("grant_latency", 64'(bus.spi_start), 1);
    wait_drain("single");

    // simultaneous 0110 after reset
    do_reset();
    pfx[1] = 64'h1111_2222_3333_4444; pfx[2] = 64'h5555_6666_7777_8888;
    push_pkt(1, DATA_BYTES, 1'b0); push_pkt(2, DATA_BYTES, 1'b0);
    pkt_left[1] = 1; pkt_left[2] = 1;
    wait_drain("pair");

    // all four held for 8 packets
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) push_pkt(i, DATA_BYTES, 1'b0);
    for (int i = 0; i < NR; i++) pkt_left[i] = 2;
    wait_drain("rr8");

    // source 2 stalls after 10 bytes, source 3 pending
    do_reset();
    stall_after[2] = 10;
    push_pkt(2, 10, 1'b1); push_pkt(3, DATA_BYTES, 1'b0);
    pkt_left[2] = 1; pkt_left[3] = 1;
    wait_drain("stall");
    check_eq("err_src_hold", 64'(bus.err_src), 2);
    stall_after[2] = DATA_BYTES;

    // gaps of TIMEOUT-1 between bytes
    gap[0] = TO - 1;
    push_pkt(0, DATA_BYTES, 1'b0);
    pkt_left[0] = 1;
    wait_drain("gaps");
    gap[0] = 0;

    // reset mid-stream
    do_reset();
    pkt_left[0] = 2; pkt_left[1] = 1;
    push_pkt(0, DATA_BYTES, 1'b0);
    begin
      int n = 0;
      while (exp_byte.size() > DATA_BYTES - 15 && n < 1000) begin
        @(negedge clk); n++;
      end
      check_eq("mid_reach15", 64'(n < 1000), 1);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check_eq("mid_gnt", 64'(bus.gnt), 0);
    check_eq("mid_bv", 64'(bus.spi_byte_valid), 0);
    check_eq("mid_busy", 64'(bus.busy), 0);
    exp_src.delete(); exp_prefix.delete(); exp_byte.delete(); exp_end.delete();
    repeat (2) @(negedge clk);
    push_pkt(0, DATA_BYTES, 1'b0); push_pkt(1, DATA_BYTES, 1'b0);
    rst = 1'b0;
    wait_drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
